// File: rtl/wave_synth.sv
// Phase-accumulator wave synthesizer: drives an external quarter-wave folder and
// synchronous ROM, then sign-restores the magnitude into a signed sample.
module wave_synth #(
  parameter int PHASE_W = 24,
  parameter int ROM_DW  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic                     note_start,
  input  logic                     note_stop,
  input  logic [PHASE_W-1:0]       freq_word,
  output logic [10:0]              addr_raw,
  input  logic [ROM_DW-1:0]        rom_data,
  output logic signed [ROM_DW:0]   sample,
  output logic                     sample_valid,
  output logic                     busy
);

  localparam int ADDR_W = 11;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, RELEASE = 2'd2} state_t;

  state_t               state, state_next;
  logic [PHASE_W-1:0]   phase, freq;
  logic [PHASE_W:0]     phase_sum;
  logic                 end_cross;
  logic                 active;
  logic                 vld_p1, vld_p2;
  logic                 sign_p1, sign_p2;
  logic                 act_p1, act_p2;

  function automatic logic signed [ROM_DW:0] apply_sign(input logic neg,
                                                         input logic [ROM_DW-1:0] mag);
    logic signed [ROM_DW:0] m;
    m = signed'({1'b0, mag});
    return neg ? -m : m;
  endfunction

  // A release ends when the step leaves the current half-wave or wraps around.
  assign phase_sum = {1'b0, phase} + {1'b0, freq};
  assign end_cross = phase_sum[PHASE_W] | (phase_sum[PHASE_W-1] ^ phase[PHASE_W-1]);
  assign active    = sample_tick && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (note_start) begin
      state_next = PLAY;
    end else begin
      case (state)
        PLAY:    if (note_stop) state_next = RELEASE;
        RELEASE: if (sample_tick && end_cross) state_next = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state == PLAY) || (state == RELEASE);
  end

  // Stage p0 -> p1: accumulator step, ROM address out, valid launched
  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      freq         <= '0;
      addr_raw     <= '0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      sample_valid <= 1'b0;
      sample       <= '0;
    end else begin
      vld_p1       <= sample_tick;
      vld_p2       <= vld_p1;
      sample_valid <= vld_p2;
      sample       <= (vld_p2 && act_p2) ? apply_sign(sign_p2, rom_data) : '0;
      if (note_start) begin
        freq  <= freq_word;
        phase <= sample_tick ? freq_word : '0;
        if (sample_tick) addr_raw <= '0;
      end else if (active) begin
        addr_raw <= phase[PHASE_W-2 -: ADDR_W];
        phase    <= (state == RELEASE && end_cross) ? '0 : phase_sum[PHASE_W-1:0];
      end
    end
  end

  // Stage p1 -> p2: sign and activity ride alongside the ROM lookup
  always_ff @(posedge clk) begin
    sign_p1 <= note_start ? 1'b0 : phase[PHASE_W-1];
    act_p1  <= note_start | (state != IDLE);
    sign_p2 <= sign_p1;
    act_p2  <= act_p1;
  end

endmodule
